fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 92 +++++++++
 tb/tb_fetch_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequentially from instruction memory into a
// circular buffer, stops on a halt word, and restarts from a redirect target.
module fetch_queue #(
   parameter int unsigned         PC_W      = 12,
   parameter int unsigned         INST_W    = 19,
   parameter int unsigned         DEPTH     = 4,
   parameter logic [PC_W-1:0]     RESET_PC  = '0,
   parameter logic [INST_W-1:0]   HALT_WORD = '1
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic [PC_W-1:0]              imem_addr,
   input  logic [INST_W-1:0]            imem_data,
   input  logic                         redirect_valid,
   input  logic [PC_W-1:0]              redirect_pc,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [INST_W-1:0]            out_inst,
   output logic [PC_W-1:0]              out_pc,
   output logic [PC_W-1:0]              out_pc_next,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         halted
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   typedef enum logic {S_FETCH, S_HALTED} state_t;

   state_t            state;
   logic [PC_W-1:0]   pc;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [LVL_W-1:0]  count;
   logic              pop;
   logic              push;

   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];

   // A full queue may still accept a push in a cycle that also pops.
   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = (state == S_FETCH) && !redirect_valid &&
                      ((count < LVL_W'(DEPTH)) || pop);

   // Control state: redirect overrides push and pop in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= S_FETCH;
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         state  <= S_FETCH;
         pc     <= redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         case (state)
            S_FETCH:  if (push && (imem_data == HALT_WORD)) state <= S_HALTED;
            S_HALTED: state <= S_HALTED;
            default:  state <= S_FETCH;
         endcase
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            pc     <= pc + PC_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + LVL_W'(1);
         else if (pop && !push) count <= count - LVL_W'(1);
      end
   end

   // Entry storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= pc;
         inst_mem[wr_ptr] <= imem_data;
      end
   end

   assign imem_addr   = pc;
   assign level       = count;
   assign halted      = (state == S_HALTED);
   assign out_inst    = out_valid ? inst_mem[rd_ptr] : '0;
   assign out_pc      = out_valid ? pc_mem[rd_ptr] : '0;
   assign out_pc_next = out_valid ? (pc_mem[rd_ptr] + PC_W'(1)) : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a queue model predicts pushes, and a scoreboard checks
// each popped head against the entry predicted when it was fetched.
module tb_fetch_queue;

   localparam int unsigned PC_W   = 12;
   localparam int unsigned INST_W = 19;
   localparam int unsigned DEPTH  = 4;

   typedef struct {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } ent_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [PC_W-1:0]   imem_addr;
   logic [INST_W-1:0] imem_data;
   logic              redirect_valid = 1'b0;
   logic [PC_W-1:0]   redirect_pc = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [INST_W-1:0] out_inst;
   logic [PC_W-1:0]   out_pc;
   logic [PC_W-1:0]   out_pc_next;
   logic [2:0]        level;
   logic              halted;

   logic [3:0]        s_addr;
   logic [18:0]       s_data;
   logic              s_valid;
   logic [18:0]       s_inst;
   logic [3:0]        s_pc;
   logic [3:0]        s_pc_next;
   logic [2:0]        s_level;
   logic              s_halted;

   int errors = 0;
   int checks = 0;

   ent_t            mq[$];
   logic [PC_W-1:0] mpc = '0;
   bit              mhalt = 1'b0;
   bit              halt_en = 1'b0;
   logic [PC_W-1:0] halt_addr = '0;

   always #5 clk = ~clk;

   function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] a);
      if (halt_en && (a == halt_addr)) return '1;
      return INST_W'(a) + INST_W'(12'h100);
   endfunction

   always_comb imem_data = mem_word(imem_addr);
   assign s_data = 19'(s_addr) + 19'(12'h100);

   fetch_queue u_dut (
      .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_pc(out_pc), .out_pc_next(out_pc_next), .level(level), .halted(halted)
   );

   fetch_queue #(.PC_W(4), .RESET_PC(4'hE)) u_small (
      .clk(clk), .rst(rst), .imem_addr(s_addr), .imem_data(s_data),
      .redirect_valid(1'b0), .redirect_pc(4'h0),
      .out_valid(s_valid), .out_ready(1'b1), .out_inst(s_inst),
      .out_pc(s_pc), .out_pc_next(s_pc_next), .level(s_level), .halted(s_halted)
   );

   task automatic model_reset();
      mq.delete();
      mpc   = '0;
      mhalt = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      redirect_valid = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   // Advance one clock: score the popped head, predict the push, then check state.
   task automatic step();
      int   sz;
      bit   pp;
      bit   pu;
      ent_t e;
      sz = mq.size();
      pp = (sz != 0) && out_ready && !redirect_valid;
      if (pp) begin
         e = mq.pop_front();
         checks++;
         if (out_pc !== e.pc || out_inst !== e.inst) begin
            errors++;
            $display("FAIL pop_head: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
         end
         checks++;
         if (out_pc_next !== e.pc + PC_W'(1)) begin
            errors++;
            $display("FAIL pop_pc_next: got %h expected %h", out_pc_next, e.pc + PC_W'(1));
         end
      end
      pu = !mhalt && !redirect_valid && ((sz < DEPTH) || pp);
      if (redirect_valid) begin
         mq.delete();
         mpc   = redirect_pc;
         mhalt = 1'b0;
      end else if (pu) begin
         e.pc   = mpc;
         e.inst = mem_word(mpc);
         mq.push_back(e);
         if (e.inst == '1) mhalt = 1'b1;
         mpc = mpc + PC_W'(1);
      end
      @(posedge clk);
      #1;
      checks++;
      if (level !== 3'(mq.size()) || out_valid !== (mq.size() != 0)) begin
         errors++;
         $display("FAIL level: level=%0d valid=%b expected level=%0d", level, out_valid, mq.size());
      end
      checks++;
      if (imem_addr !== mpc || halted !== mhalt) begin
         errors++;
         $display("FAIL fetch_state: addr=%h halted=%b expected addr=%h halted=%b", imem_addr, halted, mpc, mhalt);
      end
      if (mq.size() == 0) begin
         checks++;
         if (out_pc !== '0 || out_inst !== '0 || out_pc_next !== '0) begin
            errors++;
            $display("FAIL empty_outputs: pc=%h inst=%h next=%h expected zeros", out_pc, out_inst, out_pc_next);
         end
      end
   endtask

   task automatic test_reset();
      halt_en = 1'b0;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || level !== 3'd0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: valid=%b level=%0d halted=%b expected 0 0 0", out_valid, level, halted);
      end
      checks++;
      if (imem_addr !== 12'h000 || out_pc !== '0 || out_inst !== '0) begin
         errors++;
         $display("FAIL reset_outputs: addr=%h pc=%h inst=%h expected zeros", imem_addr, out_pc, out_inst);
      end
      apply_reset();
   endtask

   task automatic test_stream();
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_pc !== PC_W'(i) || out_inst !== INST_W'(32'h100 + i) || level !== 3'd1) begin
            errors++;
            $display("FAIL stream_%0d: pc=%h inst=%h level=%0d expected pc=%h inst=%h level=1",
                     i, out_pc, out_inst, level, i, 32'h100 + i);
         end
      end
      repeat (4) step();
   endtask

   task automatic test_backpressure();
      int exp_lvl;
      apply_reset();
      for (int i = 1; i <= 8; i++) begin
         step();
         exp_lvl = (i < 4) ? i : 4;
         checks++;
         if (level !== 3'(exp_lvl)) begin
            errors++;
            $display("FAIL fill_level_%0d: got %0d expected %0d", i, level, exp_lvl);
         end
      end
      checks++;
      if (imem_addr !== 12'h004) begin
         errors++;
         $display("FAIL full_addr: got %h expected 004", imem_addr);
      end
      out_ready = 1'b1;
      repeat (6) step();
      checks++;
      if (level !== 3'd4) begin
         errors++;
         $display("FAIL refill_level: got %0d expected 4", level);
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      out_ready = 1'b1;
      repeat (6) step();
      out_ready = 1'b0;
      repeat (2) step();
      checks++;
      if (out_pc !== 12'h005 || level !== 3'd3) begin
         errors++;
         $display("FAIL redirect_setup: pc=%h level=%0d expected 005 3", out_pc, level);
      end
      redirect_valid = 1'b1;
      redirect_pc = 12'h020;
      out_ready = 1'b1;
      step();
      checks++;
      if (level !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 12'h020) begin
         errors++;
         $display("FAIL redirect_flush: level=%0d valid=%b addr=%h expected 0 0 020", level, out_valid, imem_addr);
      end
      redirect_valid = 1'b0;
      step();
      checks++;
      if (out_pc !== 12'h020) begin
         errors++;
         $display("FAIL redirect_target: got %h expected 020", out_pc);
      end
      repeat (3) step();
   endtask

   task automatic test_halt();
      halt_en = 1'b1;
      halt_addr = 12'h003;
      apply_reset();
      out_ready = 1'b1;
      repeat (8) step();
      checks++;
      if (halted !== 1'b1 || imem_addr !== 12'h004 || level !== 3'd0) begin
         errors++;
         $display("FAIL halt_state: halted=%b addr=%h level=%0d expected 1 004 0", halted, imem_addr, level);
      end
      redirect_valid = 1'b1;
      redirect_pc = 12'h010;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (halted !== 1'b0 || imem_addr !== 12'h010) begin
         errors++;
         $display("FAIL halt_resume: halted=%b addr=%h expected 0 010", halted, imem_addr);
      end
      step();
      checks++;
      if (out_pc !== 12'h010) begin
         errors++;
         $display("FAIL halt_resume_pc: got %h expected 010", out_pc);
      end
      repeat (2) step();
      halt_en = 1'b0;
   endtask

   task automatic test_pc_wrap();
      logic [3:0] wexp [4];
      wexp = '{4'hE, 4'hF, 4'h0, 4'h1};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (s_pc !== wexp[i] || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc_%0d: pc=%h valid=%b expected %h 1", i, s_pc, s_valid, wexp[i]);
         end
         if (i == 1) begin
            checks++;
            if (s_pc_next !== 4'h0) begin
               errors++;
               $display("FAIL wrap_pc_next: got %h expected 0", s_pc_next);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      repeat (3) step();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (level !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 12'h000 || out_pc !== '0) begin
         errors++;
         $display("FAIL async_reset: level=%0d valid=%b addr=%h pc=%h expected zeros",
                  level, out_valid, imem_addr, out_pc);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      step();
      checks++;
      if (level !== 3'd1 || out_pc !== 12'h000 || out_inst !== 19'h00100) begin
         errors++;
         $display("FAIL restart: level=%0d pc=%h inst=%h expected 1 000 00100", level, out_pc, out_inst);
      end
      out_ready = 1'b1;
      repeat (4) step();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_pc_wrap();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
